lcd_port_arbiter: RTL and testbench
===================================

# lcd_port_arbiter

Sequencer and two-port arbiter for the 4-bit character-LCD bus, clocked at 50 MHz (20 ns). It runs the power-on init and configuration sequence on its own. It then shares the bus between two requesters through a round-robin req/ack handshake. Each granted byte is split into two nibble strobes, with the required setup, enable-pulse, inter-nibble and command-execution waits. It sits between the debounced user-control logic and the SF_D/LCD_E/LCD_RS/LCD_RW pins.

## Interface
- T_PWR, 750000: power-on wait before the first init nibble.
- T_INIT1, 205000: wait after init nibble 1.
- T_INIT2, 5000: wait after init nibble 2.
- T_SU, 2: RS/SF_D setup, in cycles, before LCD_E rises.
- T_EH, 12: LCD_E high width, in cycles.
- T_GAP, 50: time from the LCD_E fall of the high nibble to the setup start of the low nibble.
- T_CMD, 2000: wait after a byte, and after init nibbles 3 and 4, measured from the LCD_E fall.
- T_CLR, 82000: wait after the command bytes 0x01 and 0x02 (RS=0).
- CLK  in  1  system clock. Reset RST, synchronous, active-high; clock CLK.
- RST  in  1  synchronous, active-high reset.
- req0, req1  in  1  per-port request (level).
- rs0, rs1  in  1  register select for the port: 0 = command, 1 = data.
- byte0, byte1  in  8  byte for the port.
- ack0, ack1  out  1  one-cycle grant pulse.
- ready  out  1  high only in IDLE, after init completes.
- LCD_E  out  1  enable strobe.
- LCD_RS  out  1  register select.
- LCD_RW  out  1  constant 0.
- SF_D  out  4  data nibble.

## Operation
- **Reset values:** LCD_E=0, LCD_RS=0, LCD_RW=0, SF_D=0, ack0=ack1=0, ready=0. The RR pointer is set so that port 0 wins the first tie. State is PWR_WAIT with the timer at 0.
- **States:** PWR_WAIT → INIT_NIB (4 nibbles) → CFG (4 bytes) → IDLE ↔ XFER (SU_H, EH_H, GAP, SU_L, EH_L, WAIT).
- **Init nibbles:** 0x3, 0x3, 0x3, 0x2, all with RS=0. The waits after them are T_INIT1, T_INIT2, T_CMD and T_CMD.
- **Config bytes:** 0x28, 0x06, 0x0C, 0x01, all with RS=0. They use the normal byte transfer; 0x01 takes T_CLR.
- **Byte transfer:**
  - High nibble (byte[7:4]) first, low nibble (byte[3:0]) second.
  - Each nibble drives SF_D and LCD_RS for T_SU cycles with E low, then holds LCD_E=1 for T_EH cycles.
  - At the LCD_E fall, SF_D is held for 1 more cycle, then driven to 0.
  - LCD_RS keeps its value until the next transfer.
- **WAIT after the low nibble:** T_CLR if rs=0 and byte∈{0x01,0x02}, else T_CMD. Then go to IDLE.
- **Arbitration (IDLE only):**
  - A single requester is granted.
  - When both request, grant the port not granted last. The pointer updates on every grant.
  - Config bytes do not touch the pointer.
- **Handshake:**
  - At the edge where IDLE samples a req high: latch rs/byte, assert ack for exactly one cycle, and enter SU_H. The ack cycle is transfer cycle s.
  - The requester must drop req after seeing ack.
  - A req still high on a later IDLE sample is a new request.
  - rs/byte are don't-care after ack.
- **Requests during init or XFER** are held by the requester, not acknowledged, and not lost.
- **RST mid-transfer:** the next cycle shows reset values. No ack is issued. Init restarts from PWR_WAIT.
- **Timer:** a single down/up counter of at least 20 bits. It is reloaded at each phase entry. No wrap is possible within any phase.

## Timing
- **Cycle numbering:** cycle 0 is the first cycle after RST falls.
- **Init nibble starts:** 750000, 955014, 960028 and 962042.
- **Init LCD_E:** high during [start+2, start+13], falls at start+14.
- **Config byte starts (s):** 964056, 966134, 968212, 970290.
- **Byte at s:**
  - High nibble: E high during s+2..s+13.
  - Low nibble: setup starts s+64, E high s+66..s+77.
  - Low nibble E falls at s+78.
  - WAIT ends at s+78+T_CMD = s+2078, or s+78+T_CLR.
- **ready:** rises at cycle 1052368 with default parameters.
- **Back-to-back grants:** with req held, the earliest next ack is s+2079 after a normal byte, or s+82079 after a clear/home.
- **Latency:** from req high in IDLE to ack is 1 edge. From ack to the first LCD_E rise is 2 cycles.

## Test plan
- **Init sequence:** reset, then run to ready → LCD_E pulses at 750002, 955016, 960030, 962044 with SF_D 3, 3, 3, 2. The config nibbles are 2,8,0,6,0,C,0,1. ready=1 at 1052368.
- **Single data write:** req1 with rs1=1, byte1=0x41 → ack1 for 1 cycle at s. LCD_RS=1. SF_D=4 with E high s+2..s+13, then SF_D=1 with E high s+66..s+77. ready returns at s+2078.
- **Contention:** req0 and req1 asserted together in IDLE, both held → grants go ack0, ack1, ack0 with 2079-cycle spacing. Another 2-port contention then alternates starting from the other port.
- **Clear command:** rs0=0, byte0=0x01 → the next ack to a pending req1 comes no earlier than s+82079. rs0=1, byte0=0x01 instead gives s+2079.
- **Request during init:** req0 high from cycle 10 → no ack before 1052368. ack0 at 1052369.
- **Reset mid-transfer:** RST pulsed at s+70 → LCD_E=0, SF_D=0, ready=0, no ack in the next cycle. Init restarts, with the first E pulse 750002 cycles after RST falls.

Source files
------------

// File: rtl/lcd_port_arbiter.sv
// lcd_port_arbiter: runs the power-on init and configuration of a 4-bit
// character LCD, then grants the bus round-robin to two byte requesters.
// Each byte goes out as two nibble strobes with setup, enable, gap and
// command-execution waits, all timed by a single phase counter.
module lcd_port_arbiter #(
   parameter int T_PWR   = 750000,
   parameter int T_INIT1 = 205000,
   parameter int T_INIT2 = 5000,
   parameter int T_SU    = 2,
   parameter int T_EH    = 12,
   parameter int T_GAP   = 50,
   parameter int T_CMD   = 2000,
   parameter int T_CLR   = 82000,
   parameter int TW      = 20
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       req0,
   input  logic       req1,
   input  logic       rs0,
   input  logic       rs1,
   input  logic [7:0] byte0,
   input  logic [7:0] byte1,
   output logic       ack0,
   output logic       ack1,
   output logic       ready,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic [3:0] SF_D
);

   // Init nibbles reuse the low-nibble phases; config bytes reuse the full
   // byte path, so the whole sequencer is one small state machine.
   typedef enum logic [2:0] {
      S_PWR, S_IDLE, S_SU_H, S_EH_H, S_GAP, S_SU_L, S_EH_L, S_WAIT
   } state_t;

   state_t          state, state_n;
   logic [TW-1:0]   timer, timer_n, last_cnt;
   logic [3:0]      seq, seq_n;        // 0..3 init nibbles, 4..7 config, 8 done
   logic            cur_rs, cur_rs_n;
   logic [7:0]      cur_byte, cur_byte_n;
   logic            last, last_n;      // port granted most recently
   logic            ack0_n, ack1_n, e_n, rs_n, g1;
   logic [3:0]      d_n;
   logic            phase_end, is_clr;

   function automatic logic [3:0] init_nib(input logic [3:0] idx);
      return (idx == 4'd3) ? 4'h2 : 4'h3;
   endfunction

   function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h28;
         2'd1:    return 8'h06;
         2'd2:    return 8'h0C;
         default: return 8'h01;
      endcase
   endfunction

   assign LCD_RW = 1'b0;
   assign ready  = (state == S_IDLE);
   assign is_clr = !cur_rs && (cur_byte == 8'h01 || cur_byte == 8'h02);

   // Terminal count of the current phase; the counter runs 0..last_cnt.
   always_comb begin
      last_cnt = '0;
      case (state)
         S_PWR:          last_cnt = TW'(T_PWR - 1);
         S_SU_H, S_SU_L: last_cnt = TW'(T_SU - 1);
         S_EH_H, S_EH_L: last_cnt = TW'(T_EH - 1);
         S_GAP:          last_cnt = TW'(T_GAP - 1);
         S_WAIT: begin
            if (seq == 4'd0)      last_cnt = TW'(T_INIT1 - 1);
            else if (seq == 4'd1) last_cnt = TW'(T_INIT2 - 1);
            else if (seq < 4'd4)  last_cnt = TW'(T_CMD - 1);
            else if (is_clr)      last_cnt = TW'(T_CLR - 1);
            else                  last_cnt = TW'(T_CMD - 1);
         end
         default:        last_cnt = '0;
      endcase
   end

   assign phase_end = (timer == last_cnt);

   // Next-state, arbitration and pin values; pins change only at phase edges.
   always_comb begin
      state_n    = state;
      timer_n    = timer + TW'(1);
      seq_n      = seq;
      cur_rs_n   = cur_rs;
      cur_byte_n = cur_byte;
      last_n     = last;
      ack0_n     = 1'b0;
      ack1_n     = 1'b0;
      e_n        = LCD_E;
      rs_n       = LCD_RS;
      d_n        = SF_D;
      g1         = 1'b0;
      case (state)
         S_PWR: if (phase_end) begin
            state_n = S_SU_L;
            timer_n = '0;
            d_n     = init_nib(4'd0);
            rs_n    = 1'b0;
         end
         S_IDLE: begin
            timer_n = '0;
            if (req0 || req1) begin
               // On a tie the port not granted last wins.
               g1         = req1 && (!req0 || !last);
               last_n     = g1;
               ack0_n     = !g1;
               ack1_n     = g1;
               cur_rs_n   = g1 ? rs1 : rs0;
               cur_byte_n = g1 ? byte1 : byte0;
               d_n        = g1 ? byte1[7:4] : byte0[7:4];
               rs_n       = g1 ? rs1 : rs0;
               state_n    = S_SU_H;
            end
         end
         S_SU_H, S_SU_L: if (phase_end) begin
            state_n = (state == S_SU_H) ? S_EH_H : S_EH_L;
            timer_n = '0;
            e_n     = 1'b1;
         end
         S_EH_H, S_EH_L: if (phase_end) begin
            state_n = (state == S_EH_H) ? S_GAP : S_WAIT;
            timer_n = '0;
            e_n     = 1'b0;
         end
         S_GAP: begin
            // Data is held one cycle past the E fall, then released.
            if (timer == '0) d_n = 4'h0;
            if (phase_end) begin
               state_n = S_SU_L;
               timer_n = '0;
               d_n     = cur_byte[3:0];
            end
         end
         S_WAIT: begin
            if (timer == '0) d_n = 4'h0;
            if (phase_end) begin
               timer_n = '0;
               if (seq < 4'd3) begin
                  seq_n   = seq + 4'd1;
                  state_n = S_SU_L;
                  d_n     = init_nib(seq + 4'd1);
                  rs_n    = 1'b0;
               end else if (seq < 4'd7) begin
                  seq_n      = seq + 4'd1;
                  state_n    = S_SU_H;
                  cur_rs_n   = 1'b0;
                  cur_byte_n = cfg_byte(seq_n[1:0]);
                  d_n        = cur_byte_n[7:4];
                  rs_n       = 1'b0;
               end else begin
                  seq_n   = 4'd8;
                  state_n = S_IDLE;
               end
            end
         end
         default: state_n = S_PWR;
      endcase
   end

   // State, timer and registered pin outputs with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_PWR;
         timer    <= '0;
         seq      <= 4'd0;
         cur_rs   <= 1'b0;
         cur_byte <= 8'h00;
         last     <= 1'b1;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         LCD_E    <= 1'b0;
         LCD_RS   <= 1'b0;
         SF_D     <= 4'h0;
      end else begin
         state    <= state_n;
         timer    <= timer_n;
         seq      <= seq_n;
         cur_rs   <= cur_rs_n;
         cur_byte <= cur_byte_n;
         last     <= last_n;
         ack0     <= ack0_n;
         ack1     <= ack1_n;
         LCD_E    <= e_n;
         LCD_RS   <= rs_n;
         SF_D     <= d_n;
      end
   end

endmodule

// File: tb/tb_lcd_port_arbiter.sv
// Bench for lcd_port_arbiter with scaled-down timing. A schedule model
// (list of nibble strobes plus the cycle the bus goes idle) predicts every
// output each cycle; directed sequences add literal spot checks.
module tb_lcd_port_arbiter;
   localparam int T_PWR = 100, T_INIT1 = 30, T_INIT2 = 20, T_SU = 2, T_EH = 4;
   localparam int T_GAP = 6, T_CMD = 15, T_CLR = 40;
   localparam int NIB = T_SU + T_EH;
   localparam int BYTE_LEN = 2 * NIB + T_GAP;

   logic CLK = 1'b0, RST = 1'b1;
   logic req0 = 1'b0, req1 = 1'b0, rs0 = 1'b0, rs1 = 1'b0;
   logic [7:0] byte0 = 8'h00, byte1 = 8'h00;
   logic ack0, ack1, ready, LCD_E, LCD_RS, LCD_RW;
   logic [3:0] SF_D;

   int checks = 0, errors = 0;
   int cyc = 0;

   lcd_port_arbiter #(
      .T_PWR(T_PWR), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_SU(T_SU),
      .T_EH(T_EH), .T_GAP(T_GAP), .T_CMD(T_CMD), .T_CLR(T_CLR), .TW(20)
   ) dut (
      .CLK(CLK), .RST(RST), .req0(req0), .req1(req1), .rs0(rs0), .rs1(rs1),
      .byte0(byte0), .byte1(byte1), .ack0(ack0), .ack1(ack1), .ready(ready),
      .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .SF_D(SF_D)
   );

   always #10 CLK = ~CLK;

   // Cycle number since the last reset release.
   always @(posedge CLK) begin
      if (RST) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   // ---------------- schedule model ----------------
   typedef struct {
      int         start;
      logic [3:0] nib;
      logic       rs;
   } nib_t;

   nib_t nq[$];
   int   ready_at;
   int   ack_at[2];
   bit   last;
   bit   chk_en = 1'b0;

   function automatic int wait_for(input logic rs, input logic [7:0] b);
      return (!rs && (b == 8'h01 || b == 8'h02)) ? T_CLR : T_CMD;
   endfunction

   task automatic add_byte(input int s, input logic rs, input logic [7:0] b);
      nib_t n;
      n.start = s;               n.nib = b[7:4]; n.rs = rs; nq.push_back(n);
      n.start = s + NIB + T_GAP; n.nib = b[3:0]; n.rs = rs; nq.push_back(n);
   endtask

   task automatic model_reset();
      logic [3:0] inib[4] = '{4'h3, 4'h3, 4'h3, 4'h2};
      int         iw[4]   = '{T_INIT1, T_INIT2, T_CMD, T_CMD};
      logic [7:0] cfg[4]  = '{8'h28, 8'h06, 8'h0C, 8'h01};
      nib_t n;
      int st;
      nq.delete();
      st = T_PWR;
      for (int i = 0; i < 4; i++) begin
         n.start = st; n.nib = inib[i]; n.rs = 1'b0; nq.push_back(n);
         st += NIB + iw[i];
      end
      for (int i = 0; i < 4; i++) begin
         add_byte(st, 1'b0, cfg[i]);
         st += BYTE_LEN + wait_for(1'b0, cfg[i]);
      end
      ready_at  = st;
      ack_at[0] = -1;
      ack_at[1] = -1;
      last      = 1'b1;
   endtask

   // Compare every cycle on the falling edge, then advance the model.
   initial begin
      logic       e, r;
      logic [3:0] d;
      int         t, s;
      bit         p;
      logic       grs;
      logic [7:0] gb;
      forever begin
         @(negedge CLK);
         t = cyc;
         if (chk_en) begin
            e = 1'b0; r = 1'b0; d = 4'h0;
            foreach (nq[i]) begin
               if (t >= nq[i].start) r = nq[i].rs;
               if (t >= nq[i].start + T_SU && t < nq[i].start + NIB) e = 1'b1;
               if (t >= nq[i].start && t <= nq[i].start + NIB) d = nq[i].nib;
            end
            chk("LCD_E", LCD_E, e);
            chk("SF_D", SF_D, d);
            chk("LCD_RS", LCD_RS, r);
            chk("LCD_RW", LCD_RW, 0);
            chk("ready", ready, (t >= ready_at) ? 1 : 0);
            chk("ack0", ack0, (t == ack_at[0]) ? 1 : 0);
            chk("ack1", ack1, (t == ack_at[1]) ? 1 : 0);
         end
         if (RST) begin
            model_reset();
            chk_en = 1'b1;
         end else if (chk_en && t >= ready_at && (req0 || req1)) begin
            p         = (req0 && req1) ? !last : req1;
            last      = p;
            s         = t + 1;
            ack_at[p] = s;
            grs       = p ? rs1 : rs0;
            gb        = p ? byte1 : byte0;
            add_byte(s, grs, gb);
            ready_at  = s + BYTE_LEN + wait_for(grs, gb);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic goto(input int c);
      while (cyc < c) tick();
   endtask

   task automatic wait_ack(input int p, input int maxc, output int at);
      at = -1;
      for (int i = 0; i < maxc && at < 0; i++) begin
         tick();
         if ((p == 0 ? ack0 : ack1) === 1'b1) at = cyc;
      end
      if (at < 0) begin
         checks++; errors++;
         $display("FAIL ack%0d_timeout at cycle %0d: got none, expected ack within %0d", p, cyc, maxc);
      end
   endtask

   task automatic wait_ready(input int maxc);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < maxc && !ok; i++) begin
         tick();
         if (ready === 1'b1) ok = 1'b1;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL ready_timeout at cycle %0d: got 0, expected 1 within %0d", cyc, maxc);
      end
   endtask

   initial begin
      int s, a, b2, first_port;
      bit got;
      logic       rs_t[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [7:0] b_t[4]   = '{8'h01, 8'h01, 8'h02, 8'h03};
      int         gap_t[4] = '{59, 34, 59, 34};

      repeat (3) @(posedge CLK);
      #2 RST = 1'b0;

      // Model pins: init schedule hand-computed for the scaled timing.
      chk("model_nib1_start", nq[1].start, 136);
      chk("model_cfg0_start", nq[4].start, 204);
      chk("model_ready_at", ready_at, 361);

      // Request held from cycle 10 through the whole init.
      goto(10);
      rs0 = 1'b1; byte0 = 8'h55; req0 = 1'b1;
      goto(101); chk("init_e_before", LCD_E, 0);
      goto(102); chk("init_e_first", LCD_E, 1); chk("init_d_first", SF_D, 4'h3);
      goto(218); chk("cfg_low_nib", SF_D, 4'h8);
      goto(360); chk("ready_pre", ready, 0); chk("no_early_ack", ack0, 0);
      goto(361); chk("ready_rise", ready, 1);
      wait_ack(0, 100, s); req0 = 1'b0;
      chk("ack0_after_init", s, 362);
      wait_ready(200);

      // Single data write on port 1.
      rs1 = 1'b1; byte1 = 8'h41; req1 = 1'b1;
      wait_ack(1, 10, s); req1 = 1'b0;
      chk("single_ack_latency", s, 396);
      goto(s + 2);  chk("wr_hi_e", LCD_E, 1); chk("wr_hi_d", SF_D, 4'h4); chk("wr_rs", LCD_RS, 1);
      goto(s + 14); chk("wr_lo_e", LCD_E, 1); chk("wr_lo_d", SF_D, 4'h1);
      wait_ready(200);
      chk("wr_ready_back", cyc - s, 33);

      // Contention: both held, grants alternate 0,1,0.
      rs0 = 1'b1; byte0 = 8'h30; rs1 = 1'b1; byte1 = 8'h31;
      req0 = 1'b1; req1 = 1'b1;
      wait_ack(0, 10, s);
      wait_ack(1, 100, a);
      wait_ack(0, 100, b2);
      req0 = 1'b0; req1 = 1'b0;
      chk("rr_gap1", a - s, 34);
      chk("rr_gap2", b2 - a, 34);
      wait_ready(200);

      // Second contention starts from port 1.
      req0 = 1'b1; req1 = 1'b1;
      got = 1'b0; first_port = -1;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (ack0 === 1'b1 || ack1 === 1'b1) begin got = 1'b1; first_port = ack1 ? 1 : 0; s = cyc; end
      end
      chk("rr2_first_port", first_port, 1);
      wait_ack(0, 100, a);
      req0 = 1'b0; req1 = 1'b0;
      chk("rr2_gap", a - s, 34);
      wait_ready(200);

      // Clear/home versus plain commands and data: spacing to a pending req1.
      rs1 = 1'b1; byte1 = 8'h42;
      for (int k = 0; k < 4; k++) begin
         rs0 = rs_t[k]; byte0 = b_t[k]; req0 = 1'b1;
         wait_ack(0, 10, s); req0 = 1'b0; req1 = 1'b1;
         wait_ack(1, 200, a); req1 = 1'b0;
         chk($sformatf("clr_gap_%0d", k), a - s, gap_t[k]);
         wait_ready(200);
      end

      // Reset in the middle of the low-nibble enable pulse.
      rs0 = 1'b1; byte0 = 8'h7E; req0 = 1'b1;
      wait_ack(0, 10, s); req0 = 1'b0;
      goto(s + 15);
      chk("rst_e_before", LCD_E, 1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("rst_e", LCD_E, 0); chk("rst_d", SF_D, 0); chk("rst_ready", ready, 0);
      chk("rst_ack0", ack0, 0); chk("rst_rs", LCD_RS, 0);
      goto(101); chk("reinit_e_before", LCD_E, 0);
      goto(102); chk("reinit_e_first", LCD_E, 1);
      wait_ready(400);
      chk("reinit_ready", cyc, 361);

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #(20 * 30000);
      $display("FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
